// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam int CNT_W = 3;

endpackage

// File: rtl/mem_arb_priority.sv
// Fixed data-over-fetch priority with a starvation counter that eventually
// forces a contended fetch through.
module mem_arb_priority
  import mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic d_req,
  input  logic arb_en,
  output logic win_if,
  output logic win_d
);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved = (starve_cnt == CNT_W'(STARVE_MAX));
  assign win_d   = arb_en & d_req & ~(if_req & starved);
  assign win_if  = arb_en & if_req & ~win_d;

  // Only arbitration cycles count; a fetch that wins or goes away resets the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (arb_en) begin
      if (!if_req || win_if) begin
        starve_cnt <= '0;
      end else if (win_d && !starved) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency 64-bit memory between the fetch and MEM-stage
// requesters, one transaction at a time.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [63:0] d_rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem
);

  arb_state_t       state, state_next;
  logic             owner;
  logic             we_q;
  logic             addr2_q;
  logic [CNT_W-1:0] lat_cnt;
  logic             arb_en;
  logic             win_if, win_d;
  logic             data_valid;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[1:0], d_addr[1:0]};

  assign arb_en     = (state == IDLE);
  assign data_valid = (state == WAIT) && (lat_cnt == CNT_W'(1));
  assign stall_if   = if_req & ~if_rvalid;
  assign stall_mem  = d_req & ~d_rvalid;

  mem_arb_priority #(
    .STARVE_MAX(STARVE_MAX)
  ) u_prio (
    .clk    (clk),
    .rst    (rst),
    .if_req (if_req),
    .d_req  (d_req),
    .arb_en (arb_en),
    .win_if (win_if),
    .win_d  (win_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if_gnt     = 1'b0;
    d_gnt      = 1'b0;
    case (state)
      IDLE: begin
        if_gnt = win_if;
        d_gnt  = win_d;
        if (win_if || win_d) state_next = ISSUE;
      end
      ISSUE:   state_next = WAIT;
      WAIT:    if (data_valid) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Requests are sampled only in the grant cycle; the strobe is pre-registered
  // there so it is high exactly during ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner     <= OWN_D;
      we_q      <= 1'b0;
      addr2_q   <= 1'b0;
      lat_cnt   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      if_rvalid <= 1'b0;
      d_rvalid  <= 1'b0;
      case (state)
        IDLE: begin
          if (win_d) begin
            owner     <= OWN_D;
            we_q      <= d_we;
            addr2_q   <= d_addr[2];
            mem_addr  <= {d_addr[31:3], 3'b000};
            mem_wdata <= d_wdata;
            mem_en    <= 1'b1;
            mem_we    <= d_we;
          end else if (win_if) begin
            owner    <= OWN_IF;
            we_q     <= 1'b0;
            addr2_q  <= if_addr[2];
            mem_addr <= {if_addr[31:3], 3'b000};
            mem_en   <= 1'b1;
          end
        end
        ISSUE: lat_cnt <= CNT_W'(MEM_LAT);
        WAIT: begin
          lat_cnt <= lat_cnt - CNT_W'(1);
          if (data_valid) begin
            if (owner == OWN_IF) begin
              if_rdata  <= addr2_q ? mem_rdata[63:32] : mem_rdata[31:0];
              if_rvalid <= 1'b1;
            end else begin
              if (!we_q) d_rdata <= mem_rdata;
              d_rvalid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: queued expectations checked by a monitor,
// plus a MEM_LAT=3 instance exercised with an explicit cycle timeline.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int MEM_LAT = 1;
  localparam logic [63:0] GARBAGE = 64'hBADC_0FFE_E0DD_F00D;

  logic        clk, rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr;
  logic [63:0] d_wdata, d_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = GARBAGE;
  logic        stall_if, stall_mem;

  logic        if_req3, if_gnt3, if_rvalid3;
  logic [31:0] if_addr3, if_rdata3;
  logic        d_req3, d_we3, d_gnt3, d_rvalid3;
  logic [31:0] d_addr3;
  logic [63:0] d_wdata3, d_rdata3;
  logic        mem_en3, mem_we3;
  logic [31:0] mem_addr3;
  logic [63:0] mem_wdata3, mem_rdata3;
  logic        stall_if3, stall_mem3;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [63:0] wdata;
  } mem_exp_t;

  typedef struct {
    logic        is_d;
    logic [63:0] data;
  } rsp_exp_t;

  mem_exp_t    exp_mem[$];
  rsp_exp_t    exp_rsp[$];
  logic        exp_gnt[$];
  logic [63:0] mem_model [logic [31:0]];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int gnt_cyc = 0;
  int last_gnt_cyc = 0;
  bit spacing_chk = 0;
  bit spacing_seen = 0;

  mem_port_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) dut3 (
    .clk(clk), .rst(rst),
    .if_req(if_req3), .if_addr(if_addr3), .if_gnt(if_gnt3),
    .if_rvalid(if_rvalid3), .if_rdata(if_rdata3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_gnt(d_gnt3), .d_rvalid(d_rvalid3), .d_rdata(d_rdata3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3),
    .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata3),
    .stall_if(stall_if3), .stall_mem(stall_mem3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expectTxn(input logic is_d, input logic we, input logic [31:0] addr,
                           input logic [63:0] wdata, input logic [63:0] data, input bit with_rsp);
    mem_exp_t m;
    rsp_exp_t r;
    m.we    = is_d & we;
    m.addr  = {addr[31:3], 3'b000};
    m.wdata = wdata;
    r.is_d  = is_d;
    r.data  = data;
    exp_gnt.push_back(is_d);
    exp_mem.push_back(m);
    if (with_rsp) exp_rsp.push_back(r);
  endtask

  task automatic applyStimulus(input logic is_d, input logic we, input logic [31:0] addr,
                               input logic [63:0] wdata);
    @(posedge clk);
    #1;
    if (is_d) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      if_req = 1'b1; if_addr = addr;
    end
  endtask

  task automatic waitResp(input int n, input int budget);
    int got = 0;
    for (int c = 0; c < budget && got < n; c++) begin
      @(posedge clk);
      #1;
      if (if_rvalid || d_rvalid) got++;
    end
    if (got < n) checkOutput("resp_timeout", 64'(got), 64'(n));
    if_req = 1'b0;
    d_req  = 1'b0;
  endtask

  // Environment memory: stores update the model, loads return data only in
  // the data-valid cycle so a mistimed capture picks up garbage.
  always begin
    logic [63:0] rd;
    @(negedge clk);
    if (mem_en && !rst) begin
      if (mem_we) begin
        mem_model[mem_addr] = mem_wdata;
      end else begin
        rd = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 64'h0;
        repeat (MEM_LAT) @(posedge clk);
        #1 mem_rdata = rd;
        @(posedge clk);
        #1 mem_rdata = GARBAGE;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (if_gnt || d_gnt) begin
        checkOutput("gnt_onehot", 64'(if_gnt & d_gnt), 64'h0);
        if (exp_gnt.size() == 0) begin
          checkOutput("gnt_unexpected", 64'(d_gnt), 64'h2);
        end else begin
          checkOutput("gnt_owner", 64'(d_gnt), 64'(exp_gnt.pop_front()));
        end
        if (spacing_chk && spacing_seen)
          checkOutput("gnt_spacing", 64'(cyc - last_gnt_cyc), 64'(MEM_LAT + 3));
        if (spacing_chk) spacing_seen = 1'b1;
        last_gnt_cyc = cyc;
        gnt_cyc      = cyc;
      end
      if (mem_en) begin
        if (exp_mem.size() == 0) begin
          checkOutput("mem_en_unexpected", 64'(mem_en), 64'h0);
        end else begin
          mem_exp_t m;
          m = exp_mem.pop_front();
          checkOutput("mem_we", 64'(mem_we), 64'(m.we));
          checkOutput("mem_addr", 64'(mem_addr), 64'(m.addr));
          if (m.we) checkOutput("mem_wdata", mem_wdata, m.wdata);
          checkOutput("mem_en_cycle", 64'(cyc), 64'(gnt_cyc + 1));
        end
      end
      if (if_rvalid || d_rvalid) begin
        checkOutput("rvalid_onehot", 64'(if_rvalid & d_rvalid), 64'h0);
        if (exp_rsp.size() == 0) begin
          checkOutput("rvalid_unexpected", 64'(if_rvalid | d_rvalid), 64'h0);
        end else begin
          rsp_exp_t r;
          r = exp_rsp.pop_front();
          checkOutput("rsp_owner", 64'(d_rvalid), 64'(r.is_d));
          checkOutput("rsp_data", r.is_d ? d_rdata : {32'h0, if_rdata}, r.data);
          checkOutput("rsp_cycle", 64'(cyc), 64'(gnt_cyc + 2 + MEM_LAT));
        end
      end
      if (if_req) checkOutput("stall_if", 64'(stall_if), 64'(!if_rvalid));
      if (d_req) checkOutput("stall_mem", 64'(stall_mem), 64'(!d_rvalid));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    if_req3 = 1'b0; if_addr3 = '0; d_req3 = 1'b0; d_we3 = 1'b0;
    d_addr3 = '0; d_wdata3 = '0; mem_rdata3 = GARBAGE;
    mem_model[32'h108] = 64'hDEAD_BEEF_0123_4567;
    mem_model[32'h200] = 64'hAAAA_BBBB_CCCC_DDDD;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    checkOutput("rst_mem_en", 64'(mem_en), 64'h0);
    checkOutput("rst_mem_we", 64'(mem_we), 64'h0);
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 64'h0);
    checkOutput("rst_if_rvalid", 64'(if_rvalid), 64'h0);
    checkOutput("rst_d_rvalid", 64'(d_rvalid), 64'h0);
    checkOutput("rst_if_rdata", 64'(if_rdata), 64'h0);
    checkOutput("rst_d_rdata", d_rdata, 64'h0);
    checkOutput("rst_gnts", 64'({if_gnt, d_gnt}), 64'h0);

    $display("[TB] load 0x108");
    expectTxn(1'b1, 1'b0, 32'h108, 64'h0, 64'hDEAD_BEEF_0123_4567, 1);
    applyStimulus(1'b1, 1'b0, 32'h108, 64'h0);
    waitResp(1, 20);

    $display("[TB] fetch upper and lower words");
    expectTxn(1'b0, 1'b0, 32'h204, 64'h0, 64'h0000_0000_AAAA_BBBB, 1);
    applyStimulus(1'b0, 1'b0, 32'h204, 64'h0);
    waitResp(1, 20);
    expectTxn(1'b0, 1'b0, 32'h200, 64'h0, 64'h0000_0000_CCCC_DDDD, 1);
    applyStimulus(1'b0, 1'b0, 32'h200, 64'h0);
    waitResp(1, 20);

    $display("[TB] store 0x40 then load it back");
    expectTxn(1'b1, 1'b1, 32'h40, 64'h1122_3344_5566_7788, 64'hDEAD_BEEF_0123_4567, 1);
    applyStimulus(1'b1, 1'b1, 32'h40, 64'h1122_3344_5566_7788);
    waitResp(1, 20);
    expectTxn(1'b1, 1'b0, 32'h40, 64'h0, 64'h1122_3344_5566_7788, 1);
    applyStimulus(1'b1, 1'b0, 32'h40, 64'h0);
    waitResp(1, 20);

    $display("[TB] contention with starvation release");
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) expectTxn(1'b0, 1'b0, 32'h200, 64'h0, 64'h0000_0000_CCCC_DDDD, 1);
      else            expectTxn(1'b1, 1'b0, 32'h108, 64'h0, 64'hDEAD_BEEF_0123_4567, 1);
    end
    spacing_seen = 1'b0;
    spacing_chk  = 1'b1;
    @(posedge clk);
    #1;
    d_we = 1'b0; d_addr = 32'h108; if_addr = 32'h200;
    if_req = 1'b1; d_req = 1'b1;
    waitResp(10, 100);
    spacing_chk = 1'b0;
    @(negedge clk);
    checkOutput("starve_cleared", 64'(dut.u_prio.starve_cnt), 64'h0);

    $display("[TB] reset during an in-flight load");
    expectTxn(1'b1, 1'b0, 32'h108, 64'h0, 64'h0, 0);
    applyStimulus(1'b1, 1'b0, 32'h108, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1; d_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    expectTxn(1'b0, 1'b0, 32'h200, 64'h0, 64'h0000_0000_CCCC_DDDD, 1);
    if_req = 1'b1; if_addr = 32'h200;
    @(negedge clk);
    checkOutput("abort_mem_en", 64'(mem_en), 64'h0);
    checkOutput("abort_d_rvalid", 64'(d_rvalid), 64'h0);
    checkOutput("abort_state_idle", 64'(dut.state), 64'(IDLE));
    checkOutput("abort_if_gnt", 64'(if_gnt), 64'h1);
    waitResp(1, 20);

    $display("[TB] MEM_LAT=3 load");
    @(posedge clk);
    #1 d_req3 = 1'b1; d_we3 = 1'b0; d_addr3 = 32'h80;
    @(negedge clk);
    checkOutput("lat3_gnt", 64'(d_gnt3), 64'h1);
    checkOutput("lat3_stall_t0", 64'(stall_mem3), 64'h1);
    @(negedge clk);
    checkOutput("lat3_mem_en", 64'(mem_en3), 64'h1);
    checkOutput("lat3_mem_addr", 64'(mem_addr3), 64'h80);
    checkOutput("lat3_mem_we", 64'(mem_we3), 64'h0);
    for (int c = 2; c <= 3; c++) begin
      @(negedge clk);
      checkOutput("lat3_quiet", 64'({mem_en3, d_rvalid3}), 64'h0);
    end
    @(posedge clk);
    #1 mem_rdata3 = 64'h0F1E_2D3C_4B5A_6978;
    @(negedge clk);
    checkOutput("lat3_capture_cycle_rvalid", 64'(d_rvalid3), 64'h0);
    checkOutput("lat3_stall_t4", 64'(stall_mem3), 64'h1);
    @(posedge clk);
    #1 mem_rdata3 = GARBAGE;
    @(negedge clk);
    checkOutput("lat3_rvalid", 64'(d_rvalid3), 64'h1);
    checkOutput("lat3_rdata", d_rdata3, 64'h0F1E_2D3C_4B5A_6978);
    checkOutput("lat3_stall_t5", 64'(stall_mem3), 64'h0);
    @(posedge clk);
    #1 d_req3 = 1'b0;
    @(negedge clk);
    checkOutput("lat3_rvalid_pulse", 64'(d_rvalid3), 64'h0);

    repeat (4) @(posedge clk);
    checkOutput("gnt_queue_drained", 64'(exp_gnt.size()), 64'h0);
    checkOutput("mem_queue_drained", 64'(exp_mem.size()), 64'h0);
    checkOutput("rsp_queue_drained", 64'(exp_rsp.size()), 64'h0);
    $display("[TB] == %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
